// File: rtl/spike_act_pingpong_buf_pkg.sv
// Shared definitions for the ping-pong spike activation buffer: FSM encoding
// and a popcount helper used on the read path.
package spike_buf_pkg;

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  typedef enum logic [1:0] {
    ST_INIT  = S_INIT,
    ST_IDLE  = S_IDLE,
    ST_CLEAR = S_CLEAR
  } state_e;

  // Widest spike word the popcount helper supports; narrower words are zero-extended.
  localparam int POP_MAX = 64;

  function automatic logic [7:0] popcount(input logic [POP_MAX-1:0] word);
    logic [7:0] cnt;
    cnt = 8'd0;
    for (int i = 0; i < POP_MAX; i++) begin
      cnt = cnt + {7'd0, word[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/spike_act_pingpong_buf_if.sv
// Write / read / swap bus of the ping-pong spike activation buffer.
// master = producer/consumer layers, slave = the buffer.
interface spike_act_pingpong_buf_if #(
  parameter int WORD_BITS = 32,
  parameter int DEPTH     = 512
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(WORD_BITS + 1);

  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [WORD_BITS-1:0] wr_data;
  logic [WORD_BITS-1:0] wr_mask;
  logic                 wr_ready;
  logic                 wr_drop;
  logic                 rd_req;
  logic [AW-1:0]        rd_addr;
  logic                 rd_valid;
  logic [WORD_BITS-1:0] rd_data;
  logic [CNT_W-1:0]     rd_popcnt;
  logic                 swap_req;
  logic                 swap_ready;
  logic                 rd_bank;

  modport master (
    output wr_en, wr_addr, wr_data, wr_mask, rd_req, rd_addr, swap_req,
    input  wr_ready, wr_drop, rd_valid, rd_data, rd_popcnt, swap_ready, rd_bank
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_mask, rd_req, rd_addr, swap_req,
    output wr_ready, wr_drop, rd_valid, rd_data, rd_popcnt, swap_ready, rd_bank
  );
endinterface

// File: rtl/spike_sram_bank.sv
// One spike memory bank: synchronous 1R1W, per-bit write enable, registered read data.
// Contents are deliberately not reset; the owner clears them word by word.
module spike_sram_bank #(
  parameter int WORD_BITS = 32,
  parameter int DEPTH     = 512,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WORD_BITS-1:0] wdata,
  input  logic [WORD_BITS-1:0] wmask,
  input  logic                 re,
  input  logic [AW-1:0]        raddr,
  output logic [WORD_BITS-1:0] rdata
);

  logic [WORD_BITS-1:0] mem_r [DEPTH];
  logic [WORD_BITS-1:0] rdata_r;

  // Bit-masked write port and registered read port
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BITS; i++) begin
        if (wmask[i]) begin
          mem_r[waddr][i] <= wdata[i];
        end
      end
    end
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/spike_act_pingpong_buf.sv
// Double-buffered spike activation memory: one layer writes the WRITE bank while the
// next reads the READ bank; a swap exchanges them and the new WRITE bank clears in the background.
module spike_act_pingpong_buf
  import spike_buf_pkg::*;
#(
  parameter int WORD_BITS = 32,
  parameter int DEPTH     = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  spike_act_pingpong_buf_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(WORD_BITS + 1);

  state_e               state_r;
  logic [AW-1:0]        clr_ptr_r;
  logic                 rd_bank_r;
  logic                 last_clr_s;
  logic                 wr_ready_s;

  logic [1:0]           bank_we_s;
  logic [1:0]           bank_re_s;
  logic [AW-1:0]        waddr_s;
  logic [WORD_BITS-1:0] wdata_s;
  logic [WORD_BITS-1:0] wmask_s;
  logic [WORD_BITS-1:0] bank_rdata_s [2];

  logic                 rd_pend_r;
  logic                 rd_sel_r;
  logic                 rd_zero_r;
  logic [WORD_BITS-1:0] rd_word_s;
  logic [CNT_W-1:0]     rd_cnt_s;
  logic                 rd_valid_r;
  logic [WORD_BITS-1:0] rd_data_r;
  logic [CNT_W-1:0]     rd_popcnt_r;
  logic                 wr_drop_r;

  assign last_clr_s = (clr_ptr_r == AW'(DEPTH - 1));
  assign wr_ready_s = (state_r == ST_IDLE);

  // Bank ownership FSM: initial dual clear, idle, background clear after swap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_INIT;
      clr_ptr_r <= {AW{1'b0}};
      rd_bank_r <= 1'b1;
    end else begin
      case (state_r)
        ST_INIT, ST_CLEAR: begin
          clr_ptr_r <= clr_ptr_r + AW'(1);
          if (last_clr_s) begin
            state_r <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (bus.swap_req) begin
            state_r   <= ST_CLEAR;
            rd_bank_r <= ~rd_bank_r;
          end
        end
        default: begin
          state_r   <= ST_INIT;
          clr_ptr_r <= {AW{1'b0}};
        end
      endcase
    end
  end

  // Write-port steering: clearing owns the port outside IDLE, user writes go to ~rd_bank
  always_comb begin
    bank_we_s = 2'b00;
    waddr_s   = bus.wr_addr;
    wdata_s   = bus.wr_data;
    wmask_s   = bus.wr_mask;
    case (state_r)
      ST_INIT: begin
        bank_we_s = 2'b11;
        waddr_s   = clr_ptr_r;
        wdata_s   = {WORD_BITS{1'b0}};
        wmask_s   = {WORD_BITS{1'b1}};
      end
      ST_CLEAR: begin
        bank_we_s[~rd_bank_r] = 1'b1;
        waddr_s               = clr_ptr_r;
        wdata_s               = {WORD_BITS{1'b0}};
        wmask_s               = {WORD_BITS{1'b1}};
      end
      ST_IDLE: begin
        if (bus.wr_en) begin
          bank_we_s[~rd_bank_r] = 1'b1;
        end else begin
          bank_we_s = 2'b00;
        end
      end
      default: begin
        bank_we_s = 2'b00;
      end
    endcase
  end

  assign bank_re_s[0] = bus.rd_req & ~rd_bank_r;
  assign bank_re_s[1] = bus.rd_req &  rd_bank_r;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    spike_sram_bank #(
      .WORD_BITS (WORD_BITS),
      .DEPTH     (DEPTH)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we_s[b]),
      .waddr (waddr_s),
      .wdata (wdata_s),
      .wmask (wmask_s),
      .re    (bank_re_s[b]),
      .raddr (bus.rd_addr),
      .rdata (bank_rdata_s[b])
    );
  end

  // Bank select is captured with the request so a read on the swap cycle sees the old bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_r <= 1'b0;
      rd_sel_r  <= 1'b1;
      rd_zero_r <= 1'b0;
    end else begin
      rd_pend_r <= bus.rd_req;
      rd_sel_r  <= rd_bank_r;
      rd_zero_r <= (state_r == ST_INIT);
    end
  end

  assign rd_word_s = rd_zero_r ? {WORD_BITS{1'b0}} : bank_rdata_s[rd_sel_r];
  assign rd_cnt_s  = CNT_W'(popcount(POP_MAX'(rd_word_s)));

  // Read output register; data and popcount hold between requests
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_r  <= 1'b0;
      rd_data_r   <= {WORD_BITS{1'b0}};
      rd_popcnt_r <= {CNT_W{1'b0}};
    end else begin
      rd_valid_r <= rd_pend_r;
      if (rd_pend_r) begin
        rd_data_r   <= rd_word_s;
        rd_popcnt_r <= rd_cnt_s;
      end
    end
  end

  // Sticky flag for writes lost while the write bank was busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_drop_r <= 1'b0;
    end else if (bus.wr_en && !wr_ready_s) begin
      wr_drop_r <= 1'b1;
    end
  end

  assign bus.wr_ready   = wr_ready_s;
  assign bus.swap_ready = wr_ready_s;
  assign bus.wr_drop    = wr_drop_r;
  assign bus.rd_valid   = rd_valid_r;
  assign bus.rd_data    = rd_data_r;
  assign bus.rd_popcnt  = rd_popcnt_r;
  assign bus.rd_bank    = rd_bank_r;

endmodule

// File: tb/tb_spike_act_pingpong_buf.sv
// Scoreboard bench for spike_act_pingpong_buf: expected read words are queued when a
// read is issued and compared whenever rd_valid appears.
module tb_spike_act_pingpong_buf;

  localparam int WB    = 32;
  localparam int DEPTH = 512;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   n_init;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  spike_act_pingpong_buf_if #(.WORD_BITS(WB), .DEPTH(DEPTH)) bus ();

  spike_act_pingpong_buf #(.WORD_BITS(WB), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write(input logic [8:0] a, input logic [31:0] d, input logic [31:0] m);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_mask = m;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic read(input logic [8:0] a, input logic [31:0] d);
    exp_t e;
    e.data = d;
    e.cnt  = 6'($countones(d));
    exp_q.push_back(e);
    bus.rd_req = 1'b1; bus.rd_addr = a;
    tick();
    bus.rd_req = 1'b0;
  endtask

  task automatic swap();
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.swap_ready !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check("idle_wait", 64'(bus.swap_ready), 64'd1);
  endtask

  task automatic check_reset_vals();
    check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_rd_data", 64'(bus.rd_data), 64'd0);
    check("rst_rd_popcnt", 64'(bus.rd_popcnt), 64'd0);
    check("rst_wr_drop", 64'(bus.wr_drop), 64'd0);
    check("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
    check("rst_swap_ready", 64'(bus.swap_ready), 64'd0);
    check("rst_rd_bank", 64'(bus.rd_bank), 64'd1);
  endtask

  // Counts cycles with swap_ready low from rst release; optionally reads a word mid-INIT
  task automatic count_init(input bit do_read, output int n);
    exp_t e;
    n = 0;
    while (bus.swap_ready !== 1'b1 && n < 2000) begin
      n++;
      bus.rd_req  = do_read && (n == 10);
      bus.rd_addr = 9'd300;
      if (do_read && n == 10) begin
        e.data = 32'd0;
        e.cnt  = 6'd0;
        exp_q.push_back(e);
      end
      tick();
    end
    bus.rd_req = 1'b0;
  endtask

  // Scoreboard: every rd_valid pops one expected word
  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rd_data", 64'(bus.rd_data), 64'(mon_e.data));
        check("rd_popcnt", 64'(bus.rd_popcnt), 64'(mon_e.cnt));
      end
    end
  end

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = 9'd0; bus.wr_data = 32'd0; bus.wr_mask = 32'd0;
    bus.rd_req = 1'b0; bus.rd_addr = 9'd0; bus.swap_req = 1'b0;

    // Reset, then INIT length with swap_req held high
    repeat (3) @(negedge clk);
    check_reset_vals();
    bus.swap_req = 1'b1;
    rst = 1'b0;
    count_init(1'b1, n_init);
    check("init_len", 64'(n_init), 64'd512);
    check("bank_before_swap", 64'(bus.rd_bank), 64'd1);
    tick();
    bus.swap_req = 1'b0;
    check("bank_after_swap", 64'(bus.rd_bank), 64'd0);
    check("clear_busy", 64'(bus.swap_ready), 64'd0);

    // Plain write, plus a write on the swap cycle itself
    wait_idle();
    write(9'd5, 32'h8000_0001, 32'hFFFF_FFFF);
    bus.wr_en = 1'b1; bus.wr_addr = 9'd7; bus.wr_data = 32'h1234_5678; bus.wr_mask = 32'hFFFF_FFFF;
    swap();
    bus.wr_en = 1'b0;
    check("bank_swap2", 64'(bus.rd_bank), 64'd1);
    read(9'd5, 32'h8000_0001);
    read(9'd7, 32'h1234_5678);
    repeat (3) tick();

    // Masked write over an existing word, then read-data hold
    wait_idle();
    write(9'd5, 32'h8000_0001, 32'hFFFF_FFFF);
    write(9'd5, 32'hFFFF_FFFF, 32'h0000_00F0);
    swap();
    check("bank_swap3", 64'(bus.rd_bank), 64'd0);
    read(9'd5, 32'h8000_00F1);
    repeat (6) tick();
    check("hold_valid", 64'(bus.rd_valid), 64'd0);
    check("hold_data", 64'(bus.rd_data), 64'h8000_00F1);
    check("hold_popcnt", 64'(bus.rd_popcnt), 64'd6);

    // Write dropped during CLEAR, swap ignored during CLEAR
    check("drop_before", 64'(bus.wr_drop), 64'd0);
    write(9'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("drop_set", 64'(bus.wr_drop), 64'd1);
    swap();
    check("swap_ignored", 64'(bus.rd_bank), 64'd0);
    wait_idle();
    swap();
    check("bank_swap4", 64'(bus.rd_bank), 64'd1);
    read(9'd2, 32'd0);
    read(9'd5, 32'd0);
    read(9'd7, 32'd0);
    check("drop_sticky", 64'(bus.wr_drop), 64'd1);

    // Banks back: old contents auto-cleared, new word visible
    wait_idle();
    write(9'd11, 32'h0000_F00F, 32'hFFFF_FFFF);
    swap();
    check("bank_swap5", 64'(bus.rd_bank), 64'd0);
    read(9'd5, 32'd0);
    read(9'd11, 32'h0000_F00F);
    repeat (3) tick();

    // Asynchronous reset in the middle of CLEAR
    repeat (95) tick();
    check("mid_clear", 64'(bus.swap_ready), 64'd0);
    #2 rst = 1'b1;
    #1 check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    count_init(1'b0, n_init);
    check("init_len_again", 64'(n_init), 64'd512);
    check("bank_after_init", 64'(bus.rd_bank), 64'd1);
    check("pending_reads", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
